// File: rtl/m_mem_access.sv
// M-stage data-memory access unit.
// Decodes the load/store held in M, issues one registered request to the data
// memory, and stalls the pipeline until the access completes or times out.
// Loads return a lane-selected, sign/zero-extended word in the DONE cycle.
//
// Optional build macro: ALIGN_CHECK_EN
//   When defined, misaligned word/half accesses are rejected without a request
//   and recorded in bus_err_o.
//   When undefined, the low address bits only steer the byte lanes.
//
// Handshake: dm_req rises on the edge leaving IDLE and stays high, with
// dm_we/dm_addr/dm_byteen/dm_wdata frozen, until the first edge that samples
// dm_ready=1 (access done) or until the timeout fires. dm_ready is only
// looked at while the FSM is in BUSY.
module m_mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_M,
  input  logic [31:0] outC_M,
  input  logic [31:0] RD2_M,
  output logic        stall_o,
  output logic [31:0] ld_data_o,
  output logic        bus_err_o,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_byteen,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic [1:0]  fsm_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  // Access attributes captured with the request, used when data returns.
  logic [1:0]    acc_size;
  logic          acc_signed;
  logic          acc_store;
  logic [1:0]    acc_lane;

  logic [5:0]    opcode;
  logic          is_mem;
  logic          is_store;
  logic          is_signed;
  logic [1:0]    size_code;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic          misaligned;
  logic [31:0]   ext_data;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic          unused_instr_bits;

  assign opcode            = Instr_M[31:26];
  assign unused_instr_bits = ^Instr_M[25:0];
  assign cnt_inc           = cnt + 1'b1;
  assign fsm_state         = state;

  // Opcode decode into access size, direction and signedness.
  always_comb begin
    is_mem    = 1'b1;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size_code = SZ_W;
    case (opcode)
      OP_LW:  size_code = SZ_W;
      OP_LH:  begin size_code = SZ_H; is_signed = 1'b1; end
      OP_LHU: size_code = SZ_H;
      OP_LB:  begin size_code = SZ_B; is_signed = 1'b1; end
      OP_LBU: size_code = SZ_B;
      OP_SW:  begin size_code = SZ_W; is_store = 1'b1; end
      OP_SH:  begin size_code = SZ_H; is_store = 1'b1; end
      OP_SB:  begin size_code = SZ_B; is_store = 1'b1; end
      default: is_mem = 1'b0;
    endcase
  end

  // Byte lanes and lane-replicated store data for the op currently in M.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = RD2_M;
    case (size_code)
      SZ_B: begin
        be_next    = 4'b0001 << outC_M[1:0];
        wdata_next = {4{RD2_M[7:0]}};
      end
      SZ_H: begin
        be_next    = outC_M[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{RD2_M[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = RD2_M;
      end
    endcase
  end

`ifdef ALIGN_CHECK_EN
  // Words need addr[1:0]==0, halves need addr[0]==0; bytes are always aligned.
  always_comb begin
    misaligned = 1'b0;
    if (size_code == SZ_W) misaligned = (outC_M[1:0] != 2'b00);
    else if (size_code == SZ_H) misaligned = outC_M[0];
  end
`else
  assign misaligned = 1'b0;
`endif

  // Lane select and extension of the returned word using the latched attributes.
  always_comb begin
    sel_byte = dm_rdata[{acc_lane, 3'b000} +: 8];
    sel_half = acc_lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (acc_size)
      SZ_B:    ext_data = {{24{acc_signed & sel_byte[7]}}, sel_byte};
      SZ_H:    ext_data = {{16{acc_signed & sel_half[15]}}, sel_half};
      default: ext_data = dm_rdata;
    endcase
  end

  // Stall while a memory op waits in IDLE or the access is in flight; reset releases it.
  assign stall_o = !reset && (((state == S_IDLE) && is_mem) || (state == S_BUSY));

  // Access FSM with registered memory-side outputs and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_byteen  <= '0;
      dm_wdata   <= '0;
      ld_data_o  <= '0;
      bus_err_o  <= 1'b0;
      acc_size   <= SZ_W;
      acc_signed <= 1'b0;
      acc_store  <= 1'b0;
      acc_lane   <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mem) begin
            if (misaligned) begin
              bus_err_o <= 1'b1;
              ld_data_o <= '0;
              state     <= S_DONE;
            end else begin
              dm_req     <= 1'b1;
              dm_we      <= is_store;
              dm_addr    <= {outC_M[31:2], 2'b00};
              dm_byteen  <= be_next;
              dm_wdata   <= wdata_next;
              acc_size   <= size_code;
              acc_signed <= is_signed;
              acc_store  <= is_store;
              acc_lane   <= outC_M[1:0];
              cnt        <= '0;
              state      <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (dm_ready) begin
            dm_req <= 1'b0;
            if (!acc_store) ld_data_o <= ext_data;
            state  <= S_DONE;
          end else if (cnt_inc == CW'(TIMEOUT)) begin
            cnt       <= cnt_inc;
            dm_req    <= 1'b0;
            bus_err_o <= 1'b1;
            ld_data_o <= '0;
            state     <= S_DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_access.sv
// Bench for m_mem_access: directed cases plus randomized load/store traffic,
// checked against a byte-lane model of the memory access rules.
// Build with ALIGN_CHECK_EN defined to exercise the misalignment check.
module tb_m_mem_access;

  localparam int TIMEOUT = 16;
`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  logic        clk;
  logic        reset;
  logic [31:0] Instr_M;
  logic [31:0] outC_M;
  logic [31:0] RD2_M;
  logic        stall_o;
  logic [31:0] ld_data_o;
  logic        bus_err_o;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic [1:0]  fsm_state;

  int total;
  int bad;
  bit model_err;

  m_mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .Instr_M(Instr_M), .outC_M(outC_M), .RD2_M(RD2_M),
    .stall_o(stall_o), .ld_data_o(ld_data_o), .bus_err_o(bus_err_o),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_byteen(dm_byteen),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [5:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 1;
  endfunction

  function automatic bit is_store_op(input logic [5:0] op);
    return (op == OP_SW || op == OP_SH || op == OP_SB);
  endfunction

  function automatic int base_of(input logic [5:0] op, input logic [31:0] a);
    int sz = size_of(op);
    return int'(a[1:0]) & ~(sz - 1);
  endfunction

  function automatic bit model_misaligned(input logic [5:0] op, input logic [31:0] a);
    return ALIGN_EN && ((int'(a[1:0]) % size_of(op)) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [5:0] op, input logic [31:0] a);
    logic [3:0] be = 4'b0000;
    int b = base_of(op, a);
    for (int i = 0; i < 4; i++)
      if (i >= b && i < b + size_of(op)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] d);
    logic [31:0] w = '0;
    int sz = size_of(op);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(d >> (8 * (i % sz)));
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    int sz = size_of(op);
    logic [31:0] v = rd >> (8 * base_of(op, a));
    bit sgn = (op == OP_LB || op == OP_LH);
    if (sz < 4) begin
      v = v & ((32'h1 << (8 * sz)) - 32'h1);
      if (sgn && v[8*sz-1]) v = v - (32'h1 << (8 * sz));
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset    = 1'b1;
    Instr_M  = '0;
    outC_M   = '0;
    RD2_M    = '0;
    dm_ready = 1'b0;
    dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_err = 1'b0;
  endtask

  // Runs one memory op from its IDLE cycle to its DONE cycle and checks it.
  // Called just after a rising edge; returns just after the edge ending DONE.
  // wait_n = number of BUSY cycles without ready before ready is given.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd2,
                        input logic [31:0] rdata, input int wait_n);
    int stalls = 0;
    int busy_seen = 0;
    bit done = 1'b0;
    int exp_stalls;
    bit exp_err_now;
    logic [31:0] exp_ld;
    logic [25:0] low = 26'($urandom);
    Instr_M  = {op, low};
    outC_M   = a;
    RD2_M    = rd2;
    dm_ready = 1'b0;
    if (model_misaligned(op, a)) begin
      exp_stalls = 1; exp_err_now = 1'b1; exp_ld = '0;
    end else if (wait_n >= TIMEOUT) begin
      exp_stalls = 1 + TIMEOUT; exp_err_now = 1'b1; exp_ld = '0;
    end else begin
      exp_stalls = 2 + wait_n; exp_err_now = 1'b0; exp_ld = model_load(op, a, rdata);
    end
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (stall_o) begin
        stalls++;
        if (dm_req) begin
          total++;
          if (dm_addr !== {a[31:2], 2'b00} || dm_byteen !== model_be(op, a) ||
              dm_we !== is_store_op(op)) begin
            bad++;
            $display("FAIL busy_fields op=%h addr=%h be=%b we=%b, required addr=%h be=%b we=%b",
                     op, dm_addr, dm_byteen, dm_we, {a[31:2], 2'b00}, model_be(op, a),
                     is_store_op(op));
          end
          if (is_store_op(op)) begin
            total++;
            if (dm_wdata !== model_wdata(op, rd2)) begin
              bad++;
              $display("FAIL store_wdata op=%h got=%h required=%h", op, dm_wdata,
                       model_wdata(op, rd2));
            end
          end
          if (busy_seen == wait_n) begin
            dm_ready = 1'b1;
            dm_rdata = rdata;
          end else begin
            dm_ready = 1'b0;
            dm_rdata = $urandom;
          end
          busy_seen++;
        end else begin
          // IDLE cycle: a stray ready here must be ignored.
          dm_ready = 1'($urandom_range(0, 1));
          dm_rdata = $urandom;
        end
      end else begin
        done = 1'b1;
        if (exp_err_now) model_err = 1'b1;
        total++;
        if (stalls != exp_stalls) begin
          bad++;
          $display("FAIL stall_count op=%h got=%0d required=%0d", op, stalls, exp_stalls);
        end
        total++;
        if (dm_req !== 1'b0 || bus_err_o !== model_err) begin
          bad++;
          $display("FAIL done_state op=%h req=%b err=%b, required req=0 err=%b",
                   op, dm_req, bus_err_o, model_err);
        end
        if (!is_store_op(op) || exp_err_now) begin
          total++;
          if (ld_data_o !== exp_ld) begin
            bad++;
            $display("FAIL ld_data op=%h addr=%h got=%h required=%h", op, a, ld_data_o, exp_ld);
          end
        end
        // Ready during DONE must be ignored as well.
        dm_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1 dm_ready = 1'b0;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL op_timeout op=%h never left stall", op);
    end
    Instr_M = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0 || dm_req !== 1'b0 || dm_we !== 1'b0 || dm_addr !== 32'h0 ||
        dm_byteen !== 4'h0 || dm_wdata !== 32'h0 || ld_data_o !== 32'h0 ||
        bus_err_o !== 1'b0 || fsm_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_state stall=%b req=%b we=%b addr=%h be=%b wd=%h ld=%h err=%b st=%0d, required all zero",
               stall_o, dm_req, dm_we, dm_addr, dm_byteen, dm_wdata, ld_data_o, bus_err_o, fsm_state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_non_mem();
    Instr_M = {6'h00, 26'h0012345};
    dm_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (stall_o !== 1'b0 || dm_req !== 1'b0) begin
        bad++;
        $display("FAIL non_mem stall=%b req=%b required 0 0", stall_o, dm_req);
      end
      @(posedge clk); #1;
    end
    dm_ready = 1'b0;
    Instr_M = '0;
  endtask

  task automatic test_lw_basic();
    run_op(OP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    total++;
    if (ld_data_o !== 32'hDEADBEEF || dm_addr !== 32'h100) begin
      bad++;
      $display("FAIL lw_basic ld=%h addr=%h required DEADBEEF 00000100", ld_data_o, dm_addr);
    end
  endtask

  task automatic test_lb_lbu();
    run_op(OP_LB, 32'h103, 32'h0, 32'h80FF7F01, 1);
    total++;
    if (ld_data_o !== 32'hFFFFFF80 || dm_byteen !== 4'b1000) begin
      bad++;
      $display("FAIL lb_sign ld=%h be=%b required FFFFFF80 1000", ld_data_o, dm_byteen);
    end
    run_op(OP_LBU, 32'h103, 32'h0, 32'h80FF7F01, 0);
    total++;
    if (ld_data_o !== 32'h00000080) begin
      bad++;
      $display("FAIL lbu_zero ld=%h required 00000080", ld_data_o);
    end
    run_op(OP_LH, 32'h202, 32'h0, 32'h8001FFFF, 2);
    run_op(OP_LHU, 32'h200, 32'h0, 32'h1234F00D, 0);
  endtask

  task automatic test_sh_wait();
    run_op(OP_SH, 32'h0A2, 32'h1234ABCD, 32'h0, 3);
    total++;
    if (dm_wdata !== 32'hABCDABCD || dm_byteen !== 4'b1100 || dm_we !== 1'b1) begin
      bad++;
      $display("FAIL sh_fields wd=%h be=%b we=%b required ABCDABCD 1100 1", dm_wdata, dm_byteen, dm_we);
    end
    run_op(OP_SB, 32'h301, 32'h000000A5, 32'h0, 0);
    run_op(OP_SW, 32'h404, 32'hCAFEF00D, 32'h0, 1);
  endtask

  task automatic test_reset_mid_busy();
    Instr_M = {OP_SW, 26'h0};
    outC_M  = 32'h500;
    RD2_M   = 32'h11223344;
    @(posedge clk); #1;   // now in BUSY #1
    @(posedge clk); #1;   // now in BUSY #2
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    Instr_M = '0;
    @(negedge clk);
    total++;
    if (dm_req !== 1'b0 || stall_o !== 1'b0 || bus_err_o !== 1'b0 || fsm_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_busy req=%b stall=%b err=%b st=%0d required 0 0 0 0",
               dm_req, stall_o, bus_err_o, fsm_state);
    end
    model_err = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_op(OP_LW, 32'h600, 32'h0, 32'h01020304, 0);
    run_op(OP_SW, 32'h604, 32'h55667788, 32'h0, 0);
    run_op(OP_LBU, 32'h606, 32'h0, 32'hA1B2C3D4, 1);
  endtask

  task automatic test_random();
    logic [5:0] ops [8] = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB};
    for (int n = 0; n < 30; n++) begin
      logic [5:0] op = ops[$urandom_range(0, 7)];
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_of(op)) - 32'h1);
      run_op(op, a, $urandom, $urandom, $urandom_range(0, 5));
    end
  endtask

  task automatic test_align();
    run_op(OP_LW, 32'h102, 32'h0, 32'h89ABCDEF, 0);
    total++;
    if (bus_err_o !== ALIGN_EN) begin
      bad++;
      $display("FAIL align_err err=%b required %b", bus_err_o, ALIGN_EN);
    end
    apply_reset();
  endtask

  task automatic test_timeout();
    run_op(OP_LW, 32'h700, 32'h0, 32'h0, 99);
    run_op(OP_LW, 32'h704, 32'h0, 32'h13579BDF, 0);
    total++;
    if (bus_err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky err=%b required 1", bus_err_o);
    end
    apply_reset();
    @(negedge clk);
    total++;
    if (bus_err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_clear err=%b required 0", bus_err_o);
    end
    @(posedge clk); #1;
  endtask

  // Sequence and final report
  initial begin
    total = 0;
    bad = 0;
    model_err = 1'b0;
    test_reset();
    test_non_mem();
    test_lw_basic();
    test_lb_lbu();
    test_sh_wait();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    test_align();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
